// File: rtl/jpeg_enc_pkg.sv
// rtl/jpeg_enc_pkg.sv - shared JPEG encoder types, zig-zag table and bank-state helper
package jpeg_enc_pkg;

  localparam int COEF_DW = 12;
  localparam int BLK_LEN = 64;

  typedef logic signed [COEF_DW-1:0] coef_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Zig-zag position -> raster address within an 8x8 block
  localparam logic [5:0] ZZ_LUT [BLK_LEN] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // A bank is never written and read in the same cycle, so at most one hit applies.
  function automatic bank_state_e bank_next(
    input bank_state_e cur,
    input logic        wr_hit,
    input logic        wr_done,
    input logic        rd_hit,
    input logic        rd_done
  );
    bank_state_e nxt;
    nxt = cur;
    if (wr_hit) nxt = wr_done ? FULL : FILLING;
    if (rd_hit) nxt = rd_done ? EMPTY : DRAINING;
    return nxt;
  endfunction

endpackage

// File: rtl/fdct_zigzag_buf_if.sv
// rtl/fdct_zigzag_buf_if.sv - raster-in / zig-zag-out coefficient stream bundle
interface fdct_zigzag_buf_if #(
  parameter int DW = 12
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sof;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sof;
  logic signed [DW-1:0] out_data;
  logic                 sync_err;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_sof, out_data, sync_err
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_sof, out_data, sync_err
  );

endinterface

// File: rtl/zz_bank_ctrl.sv
// rtl/zz_bank_ctrl.sv - block index, bank select and end-of-block wrap for one side of the ping-pong buffer
module zz_bank_ctrl
  import jpeg_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       restart,
  output logic [5:0] idx,
  output logic       bank,
  output logic       done
);

  logic at_last;

  assign at_last = (idx == 6'(BLK_LEN - 1));
  assign done    = adv & ~restart & at_last;

  // restart keeps the bank: the resync datum lands at index 0 of the same bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      bank <= 1'b0;
    end else if (restart) begin
      idx  <= 6'd1;
    end else if (adv) begin
      idx <= idx + 6'd1;
      if (at_last) bank <= ~bank;
    end
  end

endmodule

// File: rtl/fdct_zigzag_buf.sv
// rtl/fdct_zigzag_buf.sv - ping-pong 8x8 coefficient buffer, raster order in, zig-zag order out
module fdct_zigzag_buf
  import jpeg_enc_pkg::*;
#(
  parameter int DW    = COEF_DW,
  parameter int NBANK = 2
) (
  input logic              clk,
  input logic              rst,
  fdct_zigzag_buf_if.slave bus
);

  if (NBANK != 2) begin : g_nbank_check
    $error("fdct_zigzag_buf: NBANK must be 2");
  end

  bank_state_e   bstate [NBANK];
  logic [DW-1:0] mem    [NBANK][BLK_LEN];

  logic [5:0]    wr_idx;
  logic [5:0]    rd_idx;
  logic [5:0]    wr_addr;
  logic          wr_bank;
  logic          rd_bank;
  logic          wr_done;
  logic          rd_done;
  logic          wr_xfer;
  logic          rd_xfer;
  logic          wr_resync;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] hold;
  logic          sync_err_q;

  // Handshakes depend only on registered bank state, never on the other side's valid/ready
  assign bus.in_ready  = (bstate[wr_bank] == EMPTY) || (bstate[wr_bank] == FILLING);
  assign bus.out_valid = (bstate[rd_bank] == FULL)  || (bstate[rd_bank] == DRAINING);

  assign wr_xfer   = bus.in_valid & bus.in_ready;
  assign wr_resync = wr_xfer & bus.in_sof & (wr_idx != 6'd0);
  assign wr_addr   = wr_resync ? 6'd0 : wr_idx;
  assign rd_xfer   = bus.out_valid & bus.out_ready;

  assign rd_word      = mem[rd_bank][ZZ_LUT[rd_idx]];
  assign bus.out_data = bus.out_valid ? rd_word : hold;
  assign bus.out_sof  = bus.out_valid & (rd_idx == 6'd0);
  assign bus.sync_err = sync_err_q;

  zz_bank_ctrl u_wr_ctrl (
    .clk     (clk),
    .rst     (rst),
    .adv     (wr_xfer),
    .restart (wr_resync),
    .idx     (wr_idx),
    .bank    (wr_bank),
    .done    (wr_done)
  );

  zz_bank_ctrl u_rd_ctrl (
    .clk     (clk),
    .rst     (rst),
    .adv     (rd_xfer),
    .restart (1'b0),
    .idx     (rd_idx),
    .bank    (rd_bank),
    .done    (rd_done)
  );

  always_ff @(posedge clk) begin
    if (wr_xfer) mem[wr_bank][wr_addr] <= bus.in_data;
  end

  // hold keeps out_data at the last delivered coefficient while no bank is readable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) bstate[b] <= EMPTY;
      hold       <= '0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= wr_resync;
      if (rd_xfer) hold <= rd_word;
      for (int b = 0; b < NBANK; b++) begin
        bstate[b] <= bank_next(bstate[b],
                               wr_xfer && (wr_bank == 1'(b)), wr_done,
                               rd_xfer && (rd_bank == 1'(b)), rd_done);
      end
    end
  end

endmodule

// File: tb/tb_fdct_zigzag_buf.sv
// tb/tb_fdct_zigzag_buf.sv - directed and randomised checks of the zig-zag ping-pong buffer
module tb_fdct_zigzag_buf;

  typedef logic signed [11:0] word_t;
  typedef struct {
    logic  sof;
    word_t data;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fdct_zigzag_buf_if #(.DW(12)) bus ();

  fdct_zigzag_buf #(.DW(12), .NBANK(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  item_t inq[$];
  item_t expq[$];
  int    zz[64];
  int    n_pass   = 0;
  int    n_fail   = 0;
  int    sync_cnt = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_block(input int base, input bit rnd);
    word_t blk[64];
    for (int i = 0; i < 64; i++) begin
      if (rnd) blk[i] = (i == 0) ? word_t'(-2048) : (i == 63) ? word_t'(2047) : word_t'($urandom);
      else     blk[i] = word_t'(base + i);
      inq.push_back('{sof: (i == 0), data: blk[i]});
    end
    for (int k = 0; k < 64; k++) expq.push_back('{sof: (k == 0), data: blk[zz[k]]});
  endtask

  // Drive on the falling edge, observe 1 ns later, transfers happen at the next rising edge
  task automatic tick(input int vpct, input int rpct, input bit chk_rdy);
    @(negedge clk);
    bus.in_valid  = (inq.size() != 0) && ($urandom_range(99) < vpct);
    bus.in_sof    = (inq.size() != 0) ? inq[0].sof  : 1'b0;
    bus.in_data   = (inq.size() != 0) ? inq[0].data : word_t'(0);
    bus.out_ready = ($urandom_range(99) < rpct);
    #1;
    if (chk_rdy && inq.size() != 0) check("in_ready_stream", bus.in_ready, 1);
    if (bus.in_valid && bus.in_ready) void'(inq.pop_front());
    if (bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) check("extra_output", bus.out_valid, 0);
      else begin
        check("out_data", bus.out_data, expq[0].data);
        check("out_sof", bus.out_sof, expq[0].sof);
        void'(expq.pop_front());
      end
    end
    if (bus.sync_err === 1'b1) sync_cnt++;
  endtask

  task automatic run(input int max_cyc, input int vpct, input int rpct, input bit chk_rdy, input string tag);
    int n = 0;
    while ((inq.size() != 0 || expq.size() != 0) && n < max_cyc) begin
      tick(vpct, rpct, chk_rdy);
      n++;
    end
    check({tag, "_complete"}, inq.size() + expq.size(), 0);
  endtask

  initial begin
    int r;
    int c;
    int n;

    r = 0;
    c = 0;
    for (int k = 0; k < 64; k++) begin
      zz[k] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end

    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset state
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sof", bus.out_sof, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_sync_err", bus.sync_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // single block: raster index as data, valid rises one cycle after the last input
    push_block(0, 1'b0);
    for (int i = 0; i < 64; i++) tick(100, 100, 1'b1);
    check("t1_valid_before", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("t1_valid_rise", bus.out_valid, 1);
    check("t1_sof_first", bus.out_sof, 1);
    check("t1_data_first", bus.out_data, 0);
    run(300, 100, 100, 1'b0, "t1");
    @(posedge clk);
    #1;
    check("t1_empty_valid", bus.out_valid, 0);
    check("t1_hold_data", bus.out_data, 63);

    // four back-to-back blocks, no backpressure
    for (int b = 0; b < 4; b++) push_block(b * 64, 1'b0);
    run(1000, 100, 100, 1'b1, "t2");

    // backpressure: both banks fill, output frozen on block 0 zig-zag index 0
    for (int b = 0; b < 3; b++) push_block(512 + b * 64, 1'b0);
    for (int i = 0; i < 200; i++) tick(100, 0, 1'b0);
    check("t3_accepted", inq.size(), 64);
    check("t3_in_ready_low", bus.in_ready, 0);
    check("t3_out_valid", bus.out_valid, 1);
    check("t3_out_sof", bus.out_sof, 1);
    check("t3_frozen_data", bus.out_data, 512);
    run(2000, 100, 100, 1'b0, "t3");
    @(posedge clk);
    #1;
    check("t3_in_ready_back", bus.in_ready, 1);

    // resync: in_sof at write index 20 discards the partial block
    sync_cnt = 0;
    for (int i = 0; i < 20; i++) inq.push_back('{sof: (i == 0), data: word_t'(100 + i)});
    push_block(300, 1'b0);
    run(500, 100, 100, 1'b0, "t4");
    check("t4_sync_pulses", sync_cnt, 1);

    // reset while draining at read index 30
    push_block(700, 1'b0);
    n = 0;
    while (expq.size() > 34 && n < 500) begin
      tick(100, 100, 1'b0);
      n++;
    end
    check("t5_reached_idx30", expq.size(), 34);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_out_valid", bus.out_valid, 0);
    check("t5_rst_in_ready", bus.in_ready, 1);
    check("t5_rst_out_sof", bus.out_sof, 0);
    expq.delete();
    inq.delete();
    #1 rst = 1'b0;
    push_block(800, 1'b0);
    run(500, 100, 100, 1'b0, "t5");

    // random handshakes with signed extremes at raster 0 and 63
    sync_cnt = 0;
    for (int b = 0; b < 150; b++) push_block(0, 1'b1);
    run(60000, 50, 50, 1'b0, "t6");
    check("t6_no_sync_err", sync_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
